// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, handshakes with instruction memory and
// presents one instruction to F/D. Optional misaligned-fetch trap: PC_ALIGN_CHECK_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] NPC,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IReady,
    input  logic [31:0] IData,
    output logic        Valid_F,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic        AdEL_F
);

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic [31:0] instr_buf;
    logic        consume;
    logic        redirect_live;
    logic        misaligned;

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;
    assign misaligned = (pc[1:0] != 2'b00);
    assign AdEL_F     = adel_q;
`else
    assign misaligned = 1'b0;
    assign AdEL_F     = 1'b0;
`endif

    // Redirect is only meaningful while the hazard unit lets D advance.
    assign redirect_live = Redirect & ~Stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        IReq       = 1'b0;
        Valid_F    = 1'b0;
        consume    = 1'b0;
        case (state)
            BOOT:  state_next = ISSUE;
            ISSUE: begin
                if (misaligned) begin
                    state_next = HOLD;
                end else begin
                    IReq       = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT:  if (IReady) state_next = HOLD;
            HOLD: begin
                Valid_F = 1'b1;
                if (!Stall) begin
                    consume    = 1'b1;
                    state_next = ISSUE;
                end
            end
            default: state_next = BOOT;
        endcase
        IAddr   = pc;
        PC_F    = pc;
        Instr_F = Valid_F ? instr_buf : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            instr_buf   <= '0;
        end else begin
            if (state == WAIT && IReady) instr_buf <= IData;
            if (state == ISSUE && misaligned) instr_buf <= '0;
            // A live redirect at consumption beats an older pending one.
            if (consume) begin
                if (redirect_live)   pc <= NPC;
                else if (pend_valid) pc <= pend_target;
                else                 pc <= pc + 32'd4;
                pend_valid <= 1'b0;
            end else if (redirect_live) begin
                pend_valid  <= 1'b1;
                pend_target <= NPC;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         adel_q <= 1'b0;
        else if (state == ISSUE && misaligned) adel_q <= 1'b1;
        else if (consume)                  adel_q <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a latency-programmable instruction memory model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] NPC = '0;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IReady = 1'b0;
    logic [31:0] IData = '0;
    logic        Valid_F;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic        AdEL_F;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned lat = 1;
    int          stray_seq = 0;
    int          stray_done = 0;
    int          cnt = -1;
    logic [31:0] req_addr = '0;
    logic [31:0] ireq_log[$];

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect), .NPC(NPC),
        .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IData(IData),
        .Valid_F(Valid_F), .Instr_F(Instr_F), .PC_F(PC_F), .AdEL_F(AdEL_F)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(negedge clk) if (IReq === 1'b1) ireq_log.push_back(IAddr);

    // Memory responder; runs 1ns after the falling edge so stimulus has settled.
    always begin
        @(negedge clk);
        #1;
        IReady = 1'b0;
        if (reset) begin
            cnt = -1;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    IReady = 1'b1;
                    IData  = word_of(req_addr);
                    cnt    = -1;
                end
            end
            if (IReq === 1'b1) begin
                req_addr = IAddr;
                cnt      = int'(lat);
            end
        end
        if (stray_seq != stray_done) begin
            IReady     = 1'b1;
            IData      = 32'hDEAD_BEEF;
            stray_done = stray_seq;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (Valid_F === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(output int base);
        @(negedge clk);
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; NPC = '0; lat = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        base = ireq_log.size();
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++; if (IReq !== 1'b0) begin miscompares++; $display("FAIL reset_ireq got %0b want 0", IReq); end
        vectors++; if (IAddr !== 32'h3000) begin miscompares++; $display("FAIL reset_iaddr got %h want 00003000", IAddr); end
        vectors++; if (Valid_F !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", Valid_F); end
        vectors++; if (Instr_F !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", Instr_F); end
        vectors++; if (PC_F !== 32'h3000) begin miscompares++; $display("FAIL reset_pcf got %h want 00003000", PC_F); end
        vectors++; if (AdEL_F !== 1'b0) begin miscompares++; $display("FAIL reset_adel got %0b want 0", AdEL_F); end
    endtask

    task automatic test_sequential;
        int base; bit ok; time t_prev; logic [31:0] exp;
        do_reset(base);
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            exp = 32'h3000 + 32'(4 * k);
            wait_valid(10, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL seq_valid%0d got timeout want Valid_F", k); end
            vectors++; if (PC_F !== exp) begin miscompares++; $display("FAIL seq_pcf%0d got %h want %h", k, PC_F, exp); end
            vectors++; if (Instr_F !== word_of(exp)) begin miscompares++; $display("FAIL seq_instr%0d got %h want %h", k, Instr_F, word_of(exp)); end
            vectors++; if (ireq_log.size() <= base + k || ireq_log[base + k] !== exp) begin
                miscompares++; $display("FAIL seq_iaddr%0d got log size %0d want %h", k, ireq_log.size(), exp); end
            if (k > 0) begin
                vectors++; if ($time - t_prev != 30) begin miscompares++; $display("FAIL seq_spacing%0d got %0t want 30", k, $time - t_prev); end
            end
            t_prev = $time;
        end
    endtask

    task automatic test_branch_delay;
        int base; bit ok;
        do_reset(base);
        wait_valid(10, ok);
        wait_valid(10, ok);
        wait_valid(10, ok);
        Redirect = 1'b1; NPC = 32'h3100;
        vectors++; if (!ok || PC_F !== 32'h3008) begin miscompares++; $display("FAIL br_delay_slot got %h want 00003008", PC_F); end
        @(negedge clk);
        Redirect = 1'b0; NPC = 32'h0BAD_0000;
        vectors++; if (IReq !== 1'b1) begin miscompares++; $display("FAIL br_ireq got %0b want 1", IReq); end
        vectors++; if (IAddr !== 32'h3100) begin miscompares++; $display("FAIL br_iaddr got %h want 00003100", IAddr); end
        wait_valid(10, ok);
        vectors++; if (!ok || PC_F !== 32'h3100) begin miscompares++; $display("FAIL br_target_pcf got %h want 00003100", PC_F); end
        vectors++; if (Instr_F !== word_of(32'h3100)) begin miscompares++; $display("FAIL br_target_instr got %h want %h", Instr_F, word_of(32'h3100)); end
    endtask

    task automatic test_pending;
        int base; bit ok;
        do_reset(base);
        lat = 5;
        wait_valid(20, ok);
        wait_valid(20, ok);
        wait_valid(20, ok);
        vectors++; if (!ok || PC_F !== 32'h3008) begin miscompares++; $display("FAIL pend_pre_pcf got %h want 00003008", PC_F); end
        @(negedge clk);
        @(negedge clk);
        Redirect = 1'b1; NPC = 32'h3200;
        @(negedge clk);
        Redirect = 1'b0; NPC = 32'hDEAD_0000;
        wait_valid(20, ok);
        vectors++; if (!ok || PC_F !== 32'h300C) begin miscompares++; $display("FAIL pend_slot_pcf got %h want 0000300c", PC_F); end
        vectors++; if (Instr_F !== word_of(32'h300C)) begin miscompares++; $display("FAIL pend_slot_instr got %h want %h", Instr_F, word_of(32'h300C)); end
        wait_valid(20, ok);
        vectors++; if (!ok || PC_F !== 32'h3200) begin miscompares++; $display("FAIL pend_target_pcf got %h want 00003200", PC_F); end
        vectors++; if (ireq_log.size() <= base + 4 || ireq_log[base + 4] !== 32'h3200) begin
            miscompares++; $display("FAIL pend_iaddr got log size %0d want 00003200 at %0d", ireq_log.size(), base + 4); end
        lat = 1;
    endtask

    task automatic test_stall;
        int base; int n0; bit ok;
        do_reset(base);
        wait_valid(10, ok);
        Stall = 1'b1;
        n0 = ireq_log.size();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++; if (Valid_F !== 1'b1) begin miscompares++; $display("FAIL stall_valid%0d got %0b want 1", i, Valid_F); end
            vectors++; if (PC_F !== 32'h3000) begin miscompares++; $display("FAIL stall_pcf%0d got %h want 00003000", i, PC_F); end
            vectors++; if (Instr_F !== word_of(32'h3000)) begin miscompares++; $display("FAIL stall_instr%0d got %h want %h", i, Instr_F, word_of(32'h3000)); end
            vectors++; if (IReq !== 1'b0) begin miscompares++; $display("FAIL stall_ireq%0d got %0b want 0", i, IReq); end
        end
        Stall = 1'b0;
        @(negedge clk);
        vectors++; if (IReq !== 1'b1 || IAddr !== 32'h3004) begin miscompares++; $display("FAIL stall_release got ireq %0b addr %h want 1 00003004", IReq, IAddr); end
        @(negedge clk);
        vectors++; if (IReq !== 1'b0) begin miscompares++; $display("FAIL stall_single_ireq got %0b want 0", IReq); end
        vectors++; if (ireq_log.size() != n0 + 1) begin miscompares++; $display("FAIL stall_ireq_count got %0d want %0d", ireq_log.size(), n0 + 1); end
    endtask

    task automatic test_reset_midfetch;
        int base; int base2; bit ok;
        do_reset(base);
        lat = 5;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (IReq === 1'b1) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_first_ireq got timeout want IReq"); end
        @(negedge clk);
        Redirect = 1'b1; NPC = 32'h3300;
        @(negedge clk);
        Redirect = 1'b0;
        reset = 1'b1;
        #1;
        vectors++; if (IReq !== 1'b0) begin miscompares++; $display("FAIL rst_async_ireq got %0b want 0", IReq); end
        vectors++; if (IAddr !== 32'h3000) begin miscompares++; $display("FAIL rst_async_iaddr got %h want 00003000", IAddr); end
        vectors++; if (Valid_F !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid got %0b want 0", Valid_F); end
        lat = 1;
        @(negedge clk);
        reset = 1'b0;
        stray_seq++;
        base2 = ireq_log.size();
        wait_valid(10, ok);
        vectors++; if (!ok || PC_F !== 32'h3000) begin miscompares++; $display("FAIL rst_refetch_pcf got %h want 00003000", PC_F); end
        vectors++; if (Instr_F !== word_of(32'h3000)) begin miscompares++; $display("FAIL rst_stray_instr got %h want %h", Instr_F, word_of(32'h3000)); end
        vectors++; if (ireq_log.size() <= base2 || ireq_log[base2] !== 32'h3000) begin
            miscompares++; $display("FAIL rst_next_iaddr got log size %0d want 00003000", ireq_log.size()); end
    endtask

    task automatic test_wrap;
        int base; bit ok;
        do_reset(base);
        wait_valid(10, ok);
        Redirect = 1'b1; NPC = 32'hFFFF_FFFC;
        @(negedge clk);
        Redirect = 1'b0;
        wait_valid(10, ok);
        vectors++; if (!ok || PC_F !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top_pcf got %h want fffffffc", PC_F); end
        wait_valid(10, ok);
        vectors++; if (!ok || PC_F !== 32'h0) begin miscompares++; $display("FAIL wrap_zero_pcf got %h want 00000000", PC_F); end
        vectors++; if (Instr_F !== word_of(32'h0)) begin miscompares++; $display("FAIL wrap_zero_instr got %h want %h", Instr_F, word_of(32'h0)); end
    endtask

    task automatic test_misaligned;
        int base; bit ok;
        do_reset(base);
        wait_valid(10, ok);
        Redirect = 1'b1; NPC = 32'h3102;
        @(negedge clk);
        Redirect = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        vectors++; if (IReq !== 1'b0) begin miscompares++; $display("FAIL align_ireq got %0b want 0", IReq); end
        @(negedge clk);
        vectors++; if (Valid_F !== 1'b1) begin miscompares++; $display("FAIL align_valid got %0b want 1", Valid_F); end
        vectors++; if (Instr_F !== 32'h0) begin miscompares++; $display("FAIL align_instr got %h want 0", Instr_F); end
        vectors++; if (AdEL_F !== 1'b1) begin miscompares++; $display("FAIL align_adel got %0b want 1", AdEL_F); end
        vectors++; if (PC_F !== 32'h3102) begin miscompares++; $display("FAIL align_pcf got %h want 00003102", PC_F); end
        @(negedge clk);
        vectors++; if (AdEL_F !== 1'b0) begin miscompares++; $display("FAIL align_adel_clear got %0b want 0", AdEL_F); end
`else
        vectors++; if (IReq !== 1'b1 || IAddr !== 32'h3102) begin miscompares++; $display("FAIL noalign_iaddr got ireq %0b addr %h want 1 00003102", IReq, IAddr); end
        wait_valid(10, ok);
        vectors++; if (!ok || PC_F !== 32'h3102) begin miscompares++; $display("FAIL noalign_pcf got %h want 00003102", PC_F); end
        vectors++; if (AdEL_F !== 1'b0) begin miscompares++; $display("FAIL noalign_adel got %0b want 0", AdEL_F); end
`endif
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch_delay;
        test_pending;
        test_stall;
        test_reset_midfetch;
        test_wrap;
        test_misaligned;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
